// File: rtl/fifo_rr_merge.sv
// Round-robin merge of NUM_INPUTS FWFT FIFO outputs into one valid/ready stream.
// The output sits behind a registered main/skid pair, so no upstream ready depends on downstream ready.
module fifo_rr_merge #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 64,
    localparam int SRC_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 ia__data_in_valid,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ia__data_in,
    output logic [NUM_INPUTS-1:0]                 oa__data_in_ready,
    output logic                                  o__data_out_valid,
    output logic [DATA_WIDTH-1:0]                 o__data_out,
    output logic [SRC_WIDTH-1:0]                  o__data_out_src,
    input  logic                                  i__data_out_ready
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SRC_WIDTH-1:0]  src;
    } beat_t;

    state_t               state;
    beat_t                main_q, skid_q, in_beat;
    logic [SRC_WIDTH-1:0] rr_ptr, grant, idx;
    logic                 grant_vld, can_accept, accept, pop;

    // First valid channel at or after rr_ptr, wrapping modulo NUM_INPUTS.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(rr_ptr) + k >= NUM_INPUTS)
                idx = SRC_WIDTH'(int'(rr_ptr) + k - NUM_INPUTS);
            else
                idx = SRC_WIDTH'(int'(rr_ptr) + k);
            if (!grant_vld && ia__data_in_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign can_accept = (state != TWO) && reset;
    assign accept     = can_accept && grant_vld;
    assign pop        = o__data_out_valid && i__data_out_ready;
    assign in_beat    = '{data: ia__data_in[grant], src: grant};

    always_comb begin
        oa__data_in_ready = '0;
        if (grant_vld) oa__data_in_ready[grant] = can_accept;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= EMPTY;
            rr_ptr <= '0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (accept)
                rr_ptr <= (grant == SRC_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + SRC_WIDTH'(1);
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_beat;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_q <= in_beat;
                        state  <= TWO;
                    end else if (accept && pop) begin
                        main_q <= in_beat;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign o__data_out_valid = (state != EMPTY);
    assign o__data_out       = main_q.data;
    assign o__data_out_src   = main_q.src;

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Scoreboard bench for fifo_rr_merge: per-channel source FIFOs, a round-robin grant model,
// and an expected-output queue whose length stands for the output stage occupancy.
module tb_fifo_rr_merge;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int QD = 64;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [N-1:0]         in_valid = '0;
    logic [N-1:0][DW-1:0] in_data = '0;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [SW-1:0]        out_src;
    logic                 out_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_rr_merge #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .ia__data_in_valid (in_valid),
        .ia__data_in       (in_data),
        .oa__data_in_ready (in_ready),
        .o__data_out_valid (out_valid),
        .o__data_out       (out_data),
        .o__data_out_src   (out_src),
        .i__data_out_ready (out_ready)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] src_mem [N][QD];
    int            head [N];
    int            tail [N];
    logic [N-1:0]  en_mask = '1;
    int            ptr = 0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic src_push(input int ch, input logic [DW-1:0] v);
        if (tail[ch] - head[ch] < QD) begin
            src_mem[ch][tail[ch] % QD] = v;
            tail[ch]++;
        end
    endtask

    // One cycle: drive at negedge, check ready just after, update model at the edge.
    task automatic step(input logic rst_n, input logic dn_rdy);
        logic [N-1:0] exp_rdy;
        int g;
        @(negedge clk);
        reset     = rst_n;
        out_ready = dn_rdy;
        for (int ch = 0; ch < N; ch++) begin
            in_valid[ch] = en_mask[ch] && (tail[ch] != head[ch]);
            in_data[ch]  = in_valid[ch] ? src_mem[ch][head[ch] % QD] : DW'($urandom);
        end
        #1;
        g = -1;
        if (rst_n && exp_q.size() < 2)
            for (int k = 0; k < N; k++)
                if (g < 0 && in_valid[(ptr + k) % N]) g = (ptr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            ptr = 0;
        end else if (g >= 0) begin
            exp_q.push_back(beat_t'{in_data[g], SW'(g)});
            head[g]++;
            ptr = (g + 1) % N;
        end
    endtask

    task automatic check_cleared();
        @(negedge clk);
        #2;
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic flush_sources();
        for (int ch = 0; ch < N; ch++) head[ch] = tail[ch];
    endtask

    // Monitor: compares whatever the DUT presents against the expected queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #3;
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_src", 32'(out_src), 32'(e.src));
            end
        end
    end

    initial begin
        for (int ch = 0; ch < N; ch++) begin
            head[ch] = 0;
            tail[ch] = 0;
            for (int i = 0; i < 8; i++) src_push(ch, DW'(8'h10 + ch));
        end

        // Reset with all channels valid: nothing may be popped upstream.
        repeat (3) step(1'b0, 1'b0);
        check_cleared();

        // Round robin with everything valid and the output draining.
        repeat (12) step(1'b1, 1'b1);
        flush_sources();
        repeat (3) step(1'b1, 1'b1);

        // Backpressure into the skid entry on a single channel.
        en_mask = 4'b0100;
        src_push(2, 8'hA0);
        src_push(2, 8'hB0);
        src_push(2, 8'hC0);
        repeat (4) step(1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1);

        // Sparse channels, grant has to wrap past the top index.
        en_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            src_push(1, DW'(8'h50 + i));
            src_push(3, DW'(8'h70 + i));
        end
        repeat (10) step(1'b1, 1'b1);

        // Fill to two entries, then reset: held data must vanish.
        en_mask = 4'b0001;
        for (int i = 0; i < 3; i++) src_push(0, DW'(8'hE0 + i));
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_cleared();
        repeat (4) step(1'b1, 1'b1);

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 3) == 0) src_push(ch, DW'($urandom));
            en_mask = N'($urandom);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0));
        end

        en_mask = '0;
        repeat (6) step(1'b1, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_rr_merge.md
Name: fifo_rr_merge

Overview:
- Merges NUM_INPUTS first-word-fall-through FIFO output channels into one valid/ready stream using round-robin arbitration.
- Sits directly downstream of a bank of bypass FIFOs, e.g. per-port push queues, and feeds the PIFO enqueue path.
- The output is fully registered through a 2-entry main/skid stage, so the upstream ready never depends combinationally on downstream ready.

Parameters:
- NUM_INPUTS, default 4: number of input channels, >=1.
- DATA_WIDTH, default 64: payload width.
- SRC_WIDTH, localparam max(1, $clog2(NUM_INPUTS)): source index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; state is reset on any clk edge where reset==0.
- ia__data_in_valid  input  [NUM_INPUTS]  per-channel valid, from FIFO o__data_out_valid.
- ia__data_in  input  DATA_WIDTH x [0:NUM_INPUTS-1]  per-channel payload.
- oa__data_in_ready  output  [NUM_INPUTS]  per-channel pop, to FIFO i__data_out_ready.
- o__data_out_valid  output  1  merged output valid.
- o__data_out  output  DATA_WIDTH  merged payload.
- o__data_out_src  output  SRC_WIDTH  index of the channel the current payload came from.
- i__data_out_ready  input  1  downstream accept.

Behaviour:
- Output stage has two entries, main and skid, each holding {data, src}.
- FSM states:
  - EMPTY: no entries held.
  - ONE: main valid.
  - TWO: main and skid valid.
- Outputs by state:
  - o__data_out_valid = (state != EMPTY).
  - o__data_out and o__data_out_src are driven from main.
  - When EMPTY, o__data_out and o__data_out_src hold their last value, or 0 after reset.
- Acceptance:
  - can_accept = (state != TWO) && (reset == 1).
  - Arbitration is combinational: search from rr_ptr upward, modulo NUM_INPUTS, for the first channel with valid=1; that channel is grant g.
  - oa__data_in_ready[g] = can_accept when a grant exists. All other ready bits are 0.
  - At most one ready bit is 1 per cycle.
  - Ready may depend on ia__data_in_valid but never on i__data_out_ready.
  - accept = can_accept && a grant exists. pop = o__data_out_valid && i__data_out_ready.
- Transitions:
  - EMPTY: accept -> ONE, main <= input.
  - ONE:
    - accept && !pop -> TWO, skid <= input.
    - accept && pop -> ONE, main <= input.
    - !accept && pop -> EMPTY.
    - Otherwise hold.
  - TWO: accept is impossible.
    - pop -> ONE, main <= skid.
    - Otherwise hold.
- Latency: accepted data appears on o__data_out the cycle after acceptance. Minimum in-to-out latency is 1 cycle. Sustained throughput is 1 beat/cycle when downstream ready stays high.
- rr_ptr:
  - On accept of channel g, rr_ptr <= (g == NUM_INPUTS-1) ? 0 : g+1.
  - With no accept, rr_ptr holds. It does not advance while stalled, so the stalled grant is preserved.
- Fairness: with all channels continuously valid and the output draining, grants cycle 0,1,...,N-1,0,...
- NUM_INPUTS == 1: the arbiter degenerates to passthrough registering, src is always 0, and rr_ptr stays 0.
- Ordering: entries leave in acceptance order. Main is always older than skid.
- Reset:
  - Synchronous. While reset==0, all oa__data_in_ready are forced 0, so no upstream element is consumed.
  - Takes effect at the next edge: state <= EMPTY, rr_ptr <= 0, main/skid data and src <= 0.
  - Reset mid-operation discards held entries without emitting them. o__data_out_valid is 0 from the first cycle after the reset edge.
- No combinational path from i__data_out_ready to any oa__data_in_ready bit.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with all inputs valid -> oa__data_in_ready=4'b0000 throughout. After release, o__data_out_valid=0 and src=0. First accept goes to ch0.
- Round-robin: N=4, DATA_WIDTH=8, all channels valid with data 8'h10+ch, i__data_out_ready=1 -> outputs 10,11,12,13,10,... with src 0,1,2,3,0, one per cycle, starting 1 cycle after the first accept.
- Backpressure/skid: ch2 valid only, data A then B; i__data_out_ready=0 -> A accepted (ONE), B accepted (TWO), then ready[2]=0. Raise ready -> A, then B, on consecutive cycles, no loss or duplication.
- Sparse/wrap: only ch3 and ch1 valid, rr_ptr=0 -> grant ch1, then ch3 (rr_ptr=0 after wrap), then ch1.
- Simultaneous accept+pop in ONE: main=X, ch0 offers Y, i__data_out_ready=1 -> X emitted, main=Y next cycle, state stays ONE.
- Reset mid-operation: state TWO, drive reset=0 for one edge -> o__data_out_valid=0 the next cycle, rr_ptr=0, and held data is never emitted.
